mac_pe_dbuf: RTL

//  Next-generation systolic MAC processing element for the conv array.

---
 rtl/mac_pe_dbuf.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/mac_pe_dbuf.sv
// Systolic MAC processing element with a double-buffered weight, weight- or output-stationary
// operation, fixed-point alignment of the product with rounding, and saturating sums.
module mac_pe_dbuf #(
    parameter int A_BITWIDTH = 16,
    parameter int A_FRAC_BIT = 8,
    parameter int W_BITWIDTH = 8,
    parameter int W_FRAC_BIT = 6,
    parameter int P_BITWIDTH = 40,
    parameter int P_FRAC_BIT = 14
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  prefetch,
    input  logic                  w_swap,
    input  logic                  conv,
    input  logic                  os_mode,
    input  logic                  drain,
    input  logic                  sat_clr,
    input  logic                  valid_i,
    input  logic [A_BITWIDTH-1:0] a_i,
    input  logic [W_BITWIDTH-1:0] w_i,
    input  logic [P_BITWIDTH-1:0] p_i,
    output logic [A_BITWIDTH-1:0] a_o,
    output logic                  valid_o,
    output logic [W_BITWIDTH-1:0] w_o,
    output logic [P_BITWIDTH-1:0] p_o,
    output logic                  sat_o
);

    localparam int PROD_W = A_BITWIDTH + W_BITWIDTH;
    localparam int SUM_W  = P_BITWIDTH + 1;
    localparam int SH     = A_FRAC_BIT + W_FRAC_BIT - P_FRAC_BIT;
    localparam logic [P_BITWIDTH-1:0] P_MAX = {1'b0, {(P_BITWIDTH-1){1'b1}}};
    localparam logic [P_BITWIDTH-1:0] P_MIN = {1'b1, {(P_BITWIDTH-1){1'b0}}};

    logic signed [A_BITWIDTH-1:0] a_q;
    logic                         valid_q;
    logic signed [W_BITWIDTH-1:0] w_shadow;
    logic signed [W_BITWIDTH-1:0] w_active;
    logic        [P_BITWIDTH-1:0] p_q;
    logic signed [P_BITWIDTH-1:0] acc;
    logic                         sat;
    logic                         mode_q;

    logic signed [PROD_W-1:0]     prod;
    logic signed [SUM_W-1:0]      prod_al;
    logic signed [SUM_W-1:0]      ws_sum;
    logic signed [SUM_W-1:0]      os_sum;
    logic        [P_BITWIDTH-1:0] p_next;
    logic signed [P_BITWIDTH-1:0] acc_next;
    logic                         sat_set;
    logic                         sat_next;

    assign prod = w_active * a_q;

    generate
        if (SH > 0) begin : g_round
            localparam logic [PROD_W:0] HALF = (PROD_W + 1)'(1) << (SH - 1);
            logic signed [PROD_W:0] biased;
            logic signed [PROD_W:0] shifted;
            // One guard bit so the rounding bias cannot wrap the largest product.
            assign biased  = {prod[PROD_W-1], prod} + HALF;
            assign shifted = biased >>> SH;
            assign prod_al = SUM_W'(shifted);
        end else if (SH < 0) begin : g_shl
            logic signed [SUM_W-1:0] ext;
            assign ext     = SUM_W'(prod);
            assign prod_al = ext <<< (-SH);
        end else begin : g_pass
            assign prod_al = SUM_W'(prod);
        end
    endgenerate

    assign ws_sum = SUM_W'($signed(p_i)) + prod_al;
    assign os_sum = SUM_W'(acc) + prod_al;

    function automatic logic [P_BITWIDTH-1:0] clamp(input logic signed [SUM_W-1:0] s);
        if (s[SUM_W-1] != s[SUM_W-2]) return s[SUM_W-1] ? P_MIN : P_MAX;
        return s[P_BITWIDTH-1:0];
    endfunction

    always_comb begin
        p_next   = p_q;
        acc_next = acc;
        sat_set  = 1'b0;
        if (!os_mode) begin
            if (!conv) begin
                p_next = '0;
            end else if (valid_q) begin
                p_next  = clamp(ws_sum);
                sat_set = ws_sum[SUM_W-1] ^ ws_sum[SUM_W-2];
            end else begin
                p_next = p_i;
            end
        end else begin
            p_next = drain ? acc : p_i;
        end
        // A mode edge discards the accumulator; p already follows the new mode above.
        if (os_mode != mode_q) begin
            acc_next = '0;
        end else if (os_mode) begin
            if (drain) begin
                acc_next = (conv && valid_q) ? prod_al[P_BITWIDTH-1:0] : '0;
            end else if (conv && valid_q) begin
                acc_next = clamp(os_sum);
                sat_set  = os_sum[SUM_W-1] ^ os_sum[SUM_W-2];
            end
        end
    end

    assign sat_next = sat_set | (sat & ~sat_clr);

    // valid_o qualifies a_o each cycle; there is no backpressure, a beat is consumed when valid.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_q      <= '0;
            valid_q  <= 1'b0;
            w_shadow <= '0;
            w_active <= '0;
            p_q      <= '0;
            acc      <= '0;
            sat      <= 1'b0;
            mode_q   <= 1'b0;
        end else begin
            a_q     <= conv ? a_i : '0;
            valid_q <= conv & valid_i;
            if (prefetch) w_shadow <= w_i;
            if (w_swap)   w_active <= w_shadow;
            p_q     <= p_next;
            acc     <= acc_next;
            sat     <= sat_next;
            mode_q  <= os_mode;
        end
    end

    assign a_o     = a_q;
    assign valid_o = valid_q;
    assign w_o     = w_shadow;
    assign p_o     = p_q;
    assign sat_o   = sat;

endmodule
